// File: rtl/sat_ctr_update_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | scu_pkg: shared sizing, init value and FSM states for the counter    |
// | update controller.                          Revision: 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

package scu_pkg;

    localparam int IDX_W  = 8;
    localparam int LANES  = 8;
    localparam int CTR_W  = 2;
    localparam int LANE_W = $clog2(LANES);
    localparam int ROW_W  = LANES * CTR_W;

    localparam logic [CTR_W-1:0] INIT_CTR = 2'b01;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } scu_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_ctr_update_ctrl_next.sv
// +----------------------------------------------------------------------+
// | sat_ctr_next: combinational saturating up/down step of one counter.  |
// |                                              Revision: 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_ctr_next
    import scu_pkg::*;
#(
    parameter int CTR_W_P = CTR_W
) (
    input  logic [CTR_W_P-1:0] i_old,
    input  logic               i_taken,
    output logic [CTR_W_P-1:0] o_new
);

    localparam logic [CTR_W_P-1:0] C_MAX = {CTR_W_P{1'b1}};
    localparam logic [CTR_W_P-1:0] C_MIN = {CTR_W_P{1'b0}};

    always_comb begin
        o_new = i_old;
        if (i_taken && (i_old != C_MAX)) begin
            o_new = i_old + 1'b1;
        end else if (!i_taken && (i_old != C_MIN)) begin
            o_new = i_old - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sat_ctr_update_ctrl.sv
// +----------------------------------------------------------------------+
// | sat_ctr_update_ctrl: init sweep, lookups and RMW updates of a        |
// | masked-write 2-bit counter array. Option: SCU_SAT_WRITE_SKIP_EN.     |
// |                                              Revision: 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_ctr_update_ctrl
    import scu_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    output logic             init_done,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_resp_valid,
    output logic [ROW_W-1:0] lk_rdata,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [2:0]       upd_lane,
    input  logic             upd_taken,
    output logic [IDX_W-1:0] W0_addr,
    output logic             W0_en,
    output logic [ROW_W-1:0] W0_data,
    output logic [LANES-1:0] W0_mask,
    output logic [IDX_W-1:0] R0_addr,
    output logic             R0_en,
    input  logic [ROW_W-1:0] R0_data
`ifdef SCU_SAT_WRITE_SKIP_EN
    ,
    output logic [31:0]      sat_skip_cnt
`endif
);

    scu_state_e        r_state;
    scu_state_e        w_state_nxt;
    logic [IDX_W-1:0]  r_sweep_cnt;
    logic              r_s1_valid;
    logic [IDX_W-1:0]  r_s1_idx;
    logic [LANE_W-1:0] r_s1_lane;
    logic              r_s1_taken;
    logic              r_lk_resp_valid;

    logic              w_run;
    logic              w_upd_accept;
    logic              w_s1_wr_en;
    logic [CTR_W-1:0]  w_old;
    logic [CTR_W-1:0]  w_new;
    logic [LANES-1:0]  w_lane_mask;
    logic [ROW_W-1:0]  w_lane_data;

    assign w_run         = (r_state == ST_RUN);
    assign w_upd_accept  = w_run && !lk_valid && upd_valid;
    assign init_done     = w_run;
    assign lk_ready      = w_run;
    assign lk_resp_valid = r_lk_resp_valid;
    assign lk_rdata      = R0_data;

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_INIT) && (r_sweep_cnt == {IDX_W{1'b1}})) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_sweep_cnt <= r_sweep_cnt + 1'b1;
            end
        end
    end

    // S1 holds the accepted update while its row is read back from the array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid      <= 1'b0;
            r_s1_idx        <= '0;
            r_s1_lane       <= '0;
            r_s1_taken      <= 1'b0;
            r_lk_resp_valid <= 1'b0;
        end else begin
            r_s1_valid      <= w_upd_accept;
            r_lk_resp_valid <= w_run && lk_valid;
            if (w_upd_accept) begin
                r_s1_idx   <= upd_idx;
                r_s1_lane  <= upd_lane[LANE_W-1:0];
                r_s1_taken <= upd_taken;
            end
        end
    end

    always_comb begin
        w_old = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_s1_lane == LANE_W'(i)) begin
                w_old = R0_data[i*CTR_W +: CTR_W];
            end
        end
    end

    sat_ctr_next #(
        .CTR_W_P (CTR_W)
    ) u_next (
        .i_old   (w_old),
        .i_taken (r_s1_taken),
        .o_new   (w_new)
    );

    always_comb begin
        w_lane_mask = '0;
        w_lane_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_s1_lane == LANE_W'(i)) begin
                w_lane_mask[i]                = 1'b1;
                w_lane_data[i*CTR_W +: CTR_W] = w_new;
            end
        end
    end

`ifdef SCU_SAT_WRITE_SKIP_EN
    logic        w_skip;
    logic [31:0] r_skip_cnt;

    assign w_skip       = r_s1_valid && (w_new == w_old);
    assign w_s1_wr_en   = r_s1_valid && !w_skip;
    assign sat_skip_cnt = r_skip_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_skip_cnt <= '0;
        end else if (w_skip) begin
            r_skip_cnt <= r_skip_cnt + 32'd1;
        end
    end
`else
    assign w_s1_wr_en = r_s1_valid;
`endif

    // The sweep write is held off while reset is asserted so the array stays quiet.
    always_comb begin
        W0_en     = 1'b0;
        W0_addr   = r_s1_idx;
        W0_mask   = w_lane_mask;
        W0_data   = w_lane_data;
        R0_en     = 1'b0;
        R0_addr   = lk_idx;
        upd_ready = 1'b0;
        if (!w_run) begin
            W0_en   = reset_n;
            W0_addr = r_sweep_cnt;
            W0_mask = {LANES{1'b1}};
            W0_data = {LANES{INIT_CTR}};
        end else begin
            W0_en = w_s1_wr_en;
            if (lk_valid) begin
                R0_en = 1'b1;
            end else begin
                upd_ready = 1'b1;
                if (upd_valid) begin
                    R0_en   = 1'b1;
                    R0_addr = upd_idx;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sat_ctr_update_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_sat_ctr_update_ctrl: scoreboard bench with array model and        |
// | counter reference model.                     Revision: 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sat_ctr_update_ctrl;
    import scu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_done, lk_ready, lk_resp_valid, upd_ready;
    logic        lk_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
    logic [7:0]  lk_idx = '0, upd_idx = '0;
    logic [2:0]  upd_lane = '0;
    logic [15:0] lk_rdata;
    logic [7:0]  W0_addr, R0_addr;
    logic        W0_en, R0_en;
    logic [15:0] W0_data, R0_data;
    logic [7:0]  W0_mask;
`ifdef SCU_SAT_WRITE_SKIP_EN
    logic [31:0] sat_skip_cnt;
`endif

    always #5 clock = ~clock;

    sat_ctr_update_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .init_done     (init_done),
        .lk_valid      (lk_valid),
        .lk_ready      (lk_ready),
        .lk_idx        (lk_idx),
        .lk_resp_valid (lk_resp_valid),
        .lk_rdata      (lk_rdata),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_idx       (upd_idx),
        .upd_lane      (upd_lane),
        .upd_taken     (upd_taken),
        .W0_addr       (W0_addr),
        .W0_en         (W0_en),
        .W0_data       (W0_data),
        .W0_mask       (W0_mask),
        .R0_addr       (R0_addr),
        .R0_en         (R0_en),
        .R0_data       (R0_data)
`ifdef SCU_SAT_WRITE_SKIP_EN
        ,
        .sat_skip_cnt  (sat_skip_cnt)
`endif
    );

    // Array model: masked write and read-address register share the clock edge.
    logic [15:0] mem [256];
    logic [7:0]  raddr = '0;
    always @(posedge clock) begin
        if (W0_en) begin
            for (int l = 0; l < 8; l++) begin
                if (W0_mask[l]) mem[W0_addr][2*l +: 2] <= W0_data[2*l +: 2];
            end
        end
        if (R0_en) raddr <= R0_addr;
    end
    assign R0_data = mem[raddr];

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  m;
        logic [15:0] d;
    } wr_t;

    int          n_tests = 0;
    int          n_fail = 0;
    int          ref_ctr [256][8];
    wr_t         wr_q[$];
    logic [15:0] lk_q[$];
    int          sweep_exp = 0;
    int          skip_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_row(input int idx);
        logic [15:0] r;
        for (int l = 0; l < 8; l++) r[2*l +: 2] = 2'(ref_ctr[idx][l]);
        return r;
    endfunction

    task automatic ref_init();
        for (int i = 0; i < 256; i++)
            for (int l = 0; l < 8; l++) ref_ctr[i][l] = 1;
        skip_exp = 0;
    endtask

    task automatic model_update(input int idx, input int lane, input bit taken);
        int old_v, new_v;
        wr_t w;
        old_v = ref_ctr[idx][lane];
        if (taken) new_v = (old_v == 3) ? 3 : old_v + 1;
        else       new_v = (old_v == 0) ? 0 : old_v - 1;
        ref_ctr[idx][lane] = new_v;
        w.a = 8'(idx);
        w.m = 8'(1 << lane);
        w.d = 16'(new_v << (2 * lane));
`ifdef SCU_SAT_WRITE_SKIP_EN
        if (new_v == old_v) skip_exp++;
        else wr_q.push_back(w);
`else
        wr_q.push_back(w);
`endif
    endtask

    // Monitor: sweep writes, update writes and lookup responses.
    always @(negedge clock) begin
        if (!reset_n) begin
            sweep_exp = 0;
        end else begin
            if (W0_en && !init_done) begin
                check("init_addr", 32'(W0_addr), 32'(sweep_exp));
                check("init_mask", 32'(W0_mask), 32'h0000_00FF);
                check("init_data", 32'(W0_data), 32'h0000_5555);
                sweep_exp++;
            end else if (W0_en) begin
                if (wr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL w0_unexpected: got write addr %0h mask %0h data %0h, expected none",
                             W0_addr, W0_mask, W0_data);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("w0_addr", 32'(W0_addr), 32'(e.a));
                    check("w0_mask", 32'(W0_mask), 32'(e.m));
                    check("w0_data", 32'(W0_data), 32'(e.d));
                end
            end
            if (lk_resp_valid) begin
                if (lk_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL lk_unexpected: got response %0h, expected none", lk_rdata);
                end else begin
                    logic [15:0] e;
                    e = lk_q.pop_front();
                    check("lk_rdata", 32'(lk_rdata), 32'(e));
                end
            end
        end
    end

    task automatic drive(input bit lkv, input logic [7:0] lki, input bit uv,
                         input logic [7:0] ui, input logic [2:0] ul, input bit ut,
                         output bit acc);
        @(posedge clock);
        #2;
        lk_valid  = lkv;
        lk_idx    = lki;
        upd_valid = uv;
        upd_idx   = ui;
        upd_lane  = ul;
        upd_taken = ut;
        #1;
        acc = 1'b0;
        if (lkv && uv) check("upd_ready_blocked", 32'(upd_ready), 32'd0);
        if (lkv && init_done) lk_q.push_back(ref_row(int'(lki)));
        if (uv && upd_ready) begin
            acc = 1'b1;
            model_update(int'(ui), int'(ul), ut);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, a);
    endtask

    task automatic lookup(input logic [7:0] idx);
        bit a;
        drive(1'b1, idx, 1'b0, 8'h00, 3'd0, 1'b0, a);
    endtask

    task automatic upd(input logic [7:0] idx, input logic [2:0] lane, input bit taken);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 20) begin
            drive(1'b0, 8'h00, 1'b1, idx, lane, taken, a);
            n++;
        end
        if (!a) check("upd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!init_done && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("init_cycles", 32'(n), 32'd256);
        check("init_writes", 32'(sweep_exp), 32'd256);
        check("lk_ready", 32'(lk_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        ref_init();
        repeat (3) @(posedge clock);
        #1;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_lk_resp_valid", 32'(lk_resp_valid), 32'd0);
        check("rst_upd_ready", 32'(upd_ready), 32'd0);
        check("rst_w0_en", 32'(W0_en), 32'd0);
        check("rst_r0_en", 32'(R0_en), 32'd0);
        #1;
        reset_n = 1'b1;
        wait_init();

        lookup(8'h3A);
        upd(8'h05, 3'd3, 1'b1);
        upd(8'h05, 3'd3, 1'b1);
        upd(8'h05, 3'd3, 1'b1);
        lookup(8'h05);
        idle(2);

        drive(1'b1, 8'h05, 1'b1, 8'h09, 3'd1, 1'b1, a);
        check("upd_accept_with_lk", 32'(a), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 8'h09, 3'd1, 1'b1, a);
        check("upd_accept_after_lk", 32'(a), 32'd1);
        lookup(8'h09);

        upd(8'h07, 3'd0, 1'b0);
        upd(8'h07, 3'd0, 1'b0);
        lookup(8'h07);

        upd(8'h30, 3'd4, 1'b1);
        lookup(8'h30);
        idle(1);

        for (int l = 0; l < 8; l++)
            for (int k = 0; k < 5; k++)
                upd(8'hFF, 3'(l), ((k + l) % 2) == 0);
        lookup(8'hFF);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 3) == 0, 8'(8'h40 + ($urandom % 4)),
                  ($urandom % 4) != 0, 8'(8'h40 + ($urandom % 4)),
                  3'($urandom % 8), 1'($urandom % 2), a);
        end
        for (int r = 0; r < 4; r++) lookup(8'(8'h40 + r));
        idle(3);

`ifdef SCU_SAT_WRITE_SKIP_EN
        check("sat_skip_cnt", sat_skip_cnt, 32'(skip_exp));
`endif
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("lk_q_drained", 32'(lk_q.size()), 32'd0);

        upd(8'h20, 3'd2, 1'b1);
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        upd_valid = 1'b0;
        lk_valid  = 1'b0;
        #1;
        check("midrst_w0_en", 32'(W0_en), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        check("midrst_lk_resp_valid", 32'(lk_resp_valid), 32'd0);
        wr_q.delete();
        lk_q.delete();
        ref_init();
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        wait_init();
        lookup(8'h20);
        upd(8'h20, 3'd2, 1'b1);
        lookup(8'h20);
        idle(3);
`ifdef SCU_SAT_WRITE_SKIP_EN
        check("sat_skip_cnt_after_rst", sat_skip_cnt, 32'(skip_exp));
`endif
        check("wr_q_drained_end", 32'(wr_q.size()), 32'd0);
        check("lk_q_drained_end", 32'(lk_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sat_ctr_update_ctrl.md
Name: sat_ctr_update_ctrl

Overview:
- Sole owner of both ports of a 256-entry x 16-bit masked-write counter array: 8 lanes of 2-bit saturating counters per row, 2-bit write-mask granularity.
- Runs an init sweep after reset, then serves predictor lookups and read-modify-write counter updates.
- Lookups have priority. Updates are single-lane increment or decrement, written back with a one-hot lane mask.

Parameters:
- IDX_W, 8, row index width (array depth = 2^IDX_W)
- LANES, 8, counters per row
- CTR_W, 2, counter width; also the width of each mask bit's field
- INIT_CTR, 2'b01, value written to every counter during the init sweep (weakly not-taken)

Ports:
- clock  in  1  core clock; also drives array W0_clk and R0_clk
- reset_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once the sweep completes
- lk_valid  in  1  lookup request
- lk_ready  out  1  equals init_done
- lk_idx  in  IDX_W  lookup row
- lk_resp_valid  out  1  lookup data valid
- lk_rdata  out  LANES*CTR_W  lookup row data
- upd_valid  in  1  update request
- upd_ready  out  1  update accepted this cycle
- upd_idx  in  IDX_W  row to update
- upd_lane  in  3  lane within the row
- upd_taken  in  1  1 = increment, 0 = decrement
- W0_addr  out  IDX_W  array write address
- W0_en  out  1  array write enable
- W0_data  out  LANES*CTR_W  array write data
- W0_mask  out  LANES  array lane mask
- R0_addr  out  IDX_W  array read address
- R0_en  out  1  array read enable
- R0_data  in  LANES*CTR_W  array read data; async from the registered address, valid the cycle after R0_en

Behaviour:
- Reset values: init_done=0, lk_resp_valid=0, upd_ready=0, W0_en=0, R0_en=0. Internal: FSM=INIT, sweep counter=0, S1 valid=0.
- FSM INIT:
  - Each cycle: W0_en=1, W0_addr=sweep_cnt, W0_mask=all ones, W0_data=INIT_CTR replicated LANES times.
  - sweep_cnt increments each cycle. After writing address 255 (256 cycles), go to RUN.
  - During INIT: R0_en=0, lk_ready=0, upd_ready=0.
- FSM RUN: init_done=1. RUN is only left via reset.
- Read-port arbitration in RUN, decided combinationally each cycle:
  - lk_valid=1: R0_en=1, R0_addr=lk_idx, upd_ready=0. lk_resp_valid=1 next cycle with lk_rdata=R0_data.
  - Otherwise: upd_ready=1. If upd_valid=1, then R0_en=1, R0_addr=upd_idx, and {idx, lane, taken} are captured into S1 with S1 valid=1.
- S1 (one cycle after update accept):
  - old = R0_data field [2*lane+1:2*lane].
  - new = old+1 if taken and old!=3; old-1 if not taken and old!=0; otherwise old.
  - W0_en=1, W0_addr=S1 idx, W0_mask=one-hot(lane), W0_data=new placed in that lane's field, 0 elsewhere.
- Update latency: accept to array write = 1 cycle. Updates are fully pipelined, one per cycle.
- Back-to-back updates to the same row or lane:
  - No bypass is needed. The write at the end of cycle t+1 lands at the same edge that registers the next read address, so the read in t+2 sees the committed value.
  - The RTL must not add a stale-data hold register on R0_data.
- A lookup in the same cycle as an S1 write to the same row returns the post-write value in the following cycle.
- Reset asserted mid-operation: in-flight S1 update and pending lk_resp are dropped. FSM returns to INIT and the sweep restarts from 0.

Optional Feature:
- Macro: SCU_SAT_WRITE_SKIP_EN.
- Defined: in S1, when new==old (saturated), W0_en=0 and the write is suppressed. A 32-bit wrapping counter sat_skip_cnt (extra output port) counts skipped writes; reset 0.
- Undefined: every S1 update writes, even when the value is unchanged; no extra port.

Decomposition:
- Package scu_pkg holds:
  - IDX_W, LANES, CTR_W, INIT_CTR
  - FSM state typedef {INIT, RUN}
  - CTR_MAX constant
- One sub-module, sat_ctr_next: purely combinational old/taken -> new. It is reused by other predictor tables.

Test Plan:
- Release reset -> W0_en high for exactly 256 cycles, addresses 0..255, mask 8'hFF, data 16'h5555; init_done rises on cycle 257. A lookup of idx 0x3A then returns 16'h5555.
- Update idx 5, lane 3, taken, 3 times back-to-back -> writes mask 8'h08 with lane-3 field 2, then 3, then 3. Lookup of idx 5 then returns 16'h55D5.
- lk_valid and upd_valid asserted together -> upd_ready=0 that cycle, lookup served. The update is accepted the next cycle after lk_valid drops.
- Decrement idx 7, lane 0 twice from 1 -> field goes 0, then 0. With SCU_SAT_WRITE_SKIP_EN, the second write is suppressed and sat_skip_cnt=1.
- Assert reset_n=0 while an S1 update is in flight -> no W0 write of the update. The sweep restarts at address 0 and init_done=0.
- Updates to idx 0xFF in all lanes alternating taken/not-taken -> each lane ends at its expected value, other lanes are untouched, and the final row is checked against a reference model.
